// File: rtl/sr_cond_pkg.sv
// Shared definitions for the SR input-conditioning stage: channel FSM encoding
// and the default debounce length.
package sr_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT           = 3;

    typedef enum logic [1:0] {
        CH_LO      = 2'd0,
        CH_PEND_HI = 2'd1,
        CH_HI      = 2'd2,
        CH_PEND_LO = 2'd3
    } chan_state_e;

endpackage

// File: rtl/sr_input_debouncer_if.sv
// Raw request inputs and conditioned SR outputs of the input debouncer.
interface sr_input_debouncer_if;
    logic s_raw;
    logic r_raw;
    logic s;
    logic r;
    logic s_level;
    logic r_level;
    logic conflict;

    modport master (
        output s_raw, r_raw,
        input  s, r, s_level, r_level, conflict
    );

    modport slave (
        input  s_raw, r_raw,
        output s, r, s_level, r_level, conflict
    );
endinterface

// File: rtl/sr_debounce_chan.sv
// One debounce channel: two-flop synchroniser, stability counter, four-state
// FSM and a registered rising-edge flag on the debounced level.
module sr_debounce_chan
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    chan_state_e      state_reg;
    logic             level_reg;
    logic             rise_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= CH_LO;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            case (state_reg)
                CH_LO: begin
                    if (sync2_reg) begin
                        state_reg <= CH_PEND_HI;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                CH_PEND_HI: begin
                    // Any low sample restarts the qualification from scratch.
                    if (!sync2_reg) begin
                        state_reg <= CH_LO;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= CH_HI;
                        cnt_reg   <= '0;
                        level_reg <= 1'b1;
                        rise_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
                CH_HI: begin
                    if (!sync2_reg) begin
                        state_reg <= CH_PEND_LO;
                        cnt_reg   <= CNT_ONE;
                    end
                end
                CH_PEND_LO: begin
                    if (sync2_reg) begin
                        state_reg <= CH_HI;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= CH_LO;
                        cnt_reg   <= '0;
                        level_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/sr_input_debouncer.sv
// Debounces raw set/reset requests into exclusive one-cycle s/r pulses.
// Build option SR_CONFLICT_STICKY_EN: conflict latches until reset.
module sr_input_debouncer
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    sr_input_debouncer_if.slave  bus
);

    // Index 0 is the set channel, index 1 the reset channel.
    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;

    assign raw_vec = {bus.r_raw, bus.s_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            sr_debounce_chan #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_vec[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    logic s_reg;
    logic r_reg;
    logic conflict_reg;
    logic both_rise;

    assign both_rise = rise_vec[0] & rise_vec[1];

    // Simultaneous rises are suppressed so S=R=1 never reaches the flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            s_reg <= rise_vec[0] & ~rise_vec[1];
            r_reg <= rise_vec[1] & ~rise_vec[0];
`ifdef SR_CONFLICT_STICKY_EN
            conflict_reg <= conflict_reg | both_rise;
`else
            conflict_reg <= both_rise;
`endif
        end
    end

    assign bus.s        = s_reg;
    assign bus.r        = r_reg;
    assign bus.conflict = conflict_reg;
    assign bus.s_level  = level_vec[0];
    assign bus.r_level  = level_vec[1];

endmodule

// File: tb/tb_sr_input_debouncer.sv
// Scenario bench for sr_input_debouncer; expected per-edge outputs are queued
// when stimulus is applied and compared one edge at a time.
module tb_sr_input_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sr_input_debouncer_if bus ();

    sr_input_debouncer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Field order: s, r, conflict, s_level, r_level
    typedef logic [4:0] obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic obs_t mk(input bit s, input bit r, input bit c,
                                input bit sl, input bit rl);
        return {s, r, c, sl, rl};
    endfunction

    function automatic obs_t sample();
        return {bus.s, bus.r, bus.conflict, bus.s_level, bus.r_level};
    endfunction

    // Leaves the bench at a falling edge with rst low and both raw inputs low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.s_raw = 1'b0;
        bus.r_raw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        @(negedge clk);
        rst = 1'b1;
        bus.s_raw = 1'b1;
        bus.r_raw = 1'b1;
        for (int e = 0; e < 2; e++) sb.push_back(mk(0, 0, 0, 0, 0));
        for (int e = 0; e < 2; e++) begin
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: reset_hold e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_hold e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
        // Release with s_raw already high: it must still debounce into one pulse.
        rst = 1'b0;
        bus.r_raw = 1'b0;
        for (int e = 0; e < 10; e++) sb.push_back(mk(e == 6, 0, 0, e >= 5, 0));
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: reset_release e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL reset_release e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_set_pulse();
        obs_t got, exp;
        do_reset();
        // Held high for 12 edges, then released: level falls, no pulse on release.
        for (int e = 0; e < 22; e++)
            sb.push_back(mk(e == 6, 0, 0, (e >= 5) && (e < 17), 0));
        for (int e = 0; e < 22; e++) begin
            bus.s_raw = (e < 12);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: set_pulse e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL set_pulse e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bounce();
        obs_t got, exp;
        logic [3:0] bounce;
        bounce = 4'b0101;
        do_reset();
        // Final stable rise starts at edge 4: level at 9, pulse after 10.
        for (int e = 0; e < 16; e++) sb.push_back(mk(0, e == 10, 0, 0, e >= 9));
        for (int e = 0; e < 16; e++) begin
            bus.r_raw = (e < 4) ? bounce[e] : 1'b1;
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: bounce e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL bounce e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_short_pulse();
        obs_t got, exp;
        do_reset();
        for (int e = 0; e < 12; e++) sb.push_back(mk(0, 0, 0, 0, 0));
        for (int e = 0; e < 12; e++) begin
            bus.s_raw = (e < 3);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: short_pulse e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL short_pulse e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_conflict();
        obs_t got, exp;
        bit   c_exp;
        do_reset();
        for (int e = 0; e < 12; e++) begin
`ifdef SR_CONFLICT_STICKY_EN
            c_exp = (e >= 6);
`else
            c_exp = (e == 6);
`endif
            sb.push_back(mk(0, 0, c_exp, e >= 5, e >= 5));
        end
        for (int e = 0; e < 12; e++) begin
            bus.s_raw = 1'b1;
            bus.r_raw = 1'b1;
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: conflict e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL conflict e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        obs_t got, exp;
        do_reset();
        // rst hits edge 4 while PEND_HI holds cnt=2; restart counts from edge 5.
        for (int e = 0; e < 16; e++) sb.push_back(mk(e == 11, 0, 0, e >= 10, 0));
        for (int e = 0; e < 16; e++) begin
            bus.s_raw = 1'b1;
            rst = (e == 4);
            @(posedge clk); #1;
            got = sample(); exp = sb.pop_front(); total++;
            $display("tb: mid_reset e=%0d got=%b exp=%b", e, got, exp);
            if (got !== exp) begin
                bad++;
                $display("FAIL mid_reset e=%0d got=%b expected=%b", e, got, exp);
            end
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.s_raw = 1'b0;
        bus.r_raw = 1'b0;
        test_reset();
        test_set_pulse();
        test_bounce();
        test_short_pulse();
        test_conflict();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
